// File: rtl/ir_decode_pkg.sv
// Shared opcode, condition-code and flag definitions for the instruction decode stage.
package ir_decode_pkg;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        COND_AL = 3'b000,
        COND_EQ = 3'b001,
        COND_NE = 3'b010,
        COND_CS = 3'b011,
        COND_CC = 3'b100,
        COND_MI = 3'b101,
        COND_PL = 3'b110,
        COND_VS = 3'b111
    } cond_t;

    // Ir[15:11]; encodings above OP_HALT are reserved.
    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_ADD  = 5'd1,
        OP_ADC  = 5'd2,
        OP_SUB  = 5'd3,
        OP_SBC  = 5'd4,
        OP_AND  = 5'd5,
        OP_OR   = 5'd6,
        OP_XOR  = 5'd7,
        OP_NOT  = 5'd8,
        OP_SHL  = 5'd9,
        OP_SHR  = 5'd10,
        OP_ASR  = 5'd11,
        OP_ROL  = 5'd12,
        OP_ROR  = 5'd13,
        OP_CMP  = 5'd14,
        OP_TST  = 5'd15,
        OP_MOV  = 5'd16,
        OP_MOVI = 5'd17,
        OP_ADDI = 5'd18,
        OP_LD   = 5'd19,
        OP_ST   = 5'd20,
        OP_BR   = 5'd21,
        OP_JMP  = 5'd22,
        OP_HALT = 5'd23
    } Opcode_t;

    function automatic logic is_legal_opcode(Opcode_t op);
        return (op <= OP_HALT);
    endfunction

endpackage

// File: rtl/ir_decode_cond_eval.sv
// Combinational branch-condition evaluator: condition code against a flag vector.
module ir_decode_cond_eval
    import ir_decode_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  cond_t             i_cond,
    input  logic [FLAG_W-1:0] i_flags,
    output logic              o_true
);

    always_comb begin
        o_true = 1'b0;
        case (i_cond)
            COND_AL: o_true = 1'b1;
            COND_EQ: o_true = i_flags[FLAG_Z];
            COND_NE: o_true = ~i_flags[FLAG_Z];
            COND_CS: o_true = i_flags[FLAG_C];
            COND_CC: o_true = ~i_flags[FLAG_C];
            COND_MI: o_true = i_flags[FLAG_N];
            COND_PL: o_true = ~i_flags[FLAG_N];
            COND_VS: o_true = i_flags[FLAG_V];
            default: o_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/ir_decode.sv
// Instruction register, field decode and architectural flag register.
// Optional ILLEGAL_OP_TRAP_EN adds IllegalOp and replaces reserved opcodes with NOP at commit.
module ir_decode
    import ir_decode_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FLAG_W = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] SysBus,
    input  logic              IrWe,
    input  logic              AluWe,
    input  logic [FLAG_W-1:0] AluFlags,
    output logic [9:0]        OpcodeCondIn,
    output logic [FLAG_W-1:0] Flags,
    output logic              IrValid,
    output logic [2:0]        Rd,
    output logic [2:0]        Rs1,
    output logic [2:0]        Rs2,
    output logic [DATA_W-1:0] Imm8,
    output logic [DATA_W-1:0] Imm5,
    output logic              CarryIn,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic              IllegalOp,
`endif
    output logic              CondTrue
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } load_state_t;

    load_state_t       r_state;
    load_state_t       w_state_next;
    logic              w_shadow_we;
    logic              w_commit;
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] w_commit_word;
    logic [DATA_W-1:0] w_ir_next;
    logic [FLAG_W-1:0] r_flags;
    logic [FLAG_W-1:0] w_flags_next;
    logic              r_ir_valid;
    logic              r_cond_true;
    logic              w_cond_next;

    always_ff @(posedge Clock) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_shadow_we  = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (IrWe) begin
                    w_shadow_we  = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (IrWe) begin
                    w_shadow_we = 1'b1;
                end else begin
                    w_commit     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic w_legal;
    logic r_illegal;

    assign w_legal       = is_legal_opcode(Opcode_t'(r_shadow[15:11]));
    assign w_commit_word = w_legal ? r_shadow : '0;

    always_ff @(posedge Clock) begin
        if (Reset)         r_illegal <= 1'b0;
        else if (w_commit) r_illegal <= ~w_legal;
    end

    assign IllegalOp = r_illegal;
`else
    assign w_commit_word = r_shadow;
`endif

    // CondTrue is registered from the post-edge Ir/flags so it lines up with them.
    assign w_ir_next    = w_commit ? w_commit_word : r_ir;
    assign w_flags_next = AluWe ? AluFlags : r_flags;

    ir_decode_cond_eval #(
        .FLAG_W (FLAG_W)
    ) u_cond_eval (
        .i_cond  (cond_t'(w_ir_next[10:8])),
        .i_flags (w_flags_next),
        .o_true  (w_cond_next)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_shadow    <= '0;
            r_ir        <= '0;
            r_flags     <= '0;
            r_ir_valid  <= 1'b0;
            r_cond_true <= 1'b0;
        end else begin
            if (w_shadow_we) r_shadow <= SysBus;
            r_ir        <= w_ir_next;
            r_flags     <= w_flags_next;
            r_ir_valid  <= w_commit;
            r_cond_true <= w_cond_next;
        end
    end

    assign OpcodeCondIn = r_ir[15:6];
    assign Rd           = r_ir[10:8];
    assign Rs1          = r_ir[7:5];
    assign Rs2          = r_ir[4:2];
    assign Imm8         = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
    assign Imm5         = {{(DATA_W-5){r_ir[4]}}, r_ir[4:0]};
    assign Flags        = r_flags;
    assign CarryIn      = r_flags[FLAG_C];
    assign IrValid      = r_ir_valid;
    assign CondTrue     = r_cond_true;

endmodule

// File: tb/tb_ir_decode.sv
// Self-checking bench for ir_decode against a cycle-level behavioural model.
module tb_ir_decode;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] SysBus = '0;
    logic        IrWe = 1'b0;
    logic        AluWe = 1'b0;
    logic [3:0]  AluFlags = '0;
    logic [9:0]  OpcodeCondIn;
    logic [3:0]  Flags;
    logic        IrValid;
    logic [2:0]  Rd, Rs1, Rs2;
    logic [15:0] Imm8, Imm5;
    logic        CarryIn;
    logic        CondTrue;
`ifdef ILLEGAL_OP_TRAP_EN
    logic        IllegalOp;
    localparam int OBS_W = 59;
`else
    localparam int OBS_W = 58;
`endif

    always #5 Clock = ~Clock;

    ir_decode #(.DATA_W(16), .FLAG_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .SysBus(SysBus), .IrWe(IrWe),
        .AluWe(AluWe), .AluFlags(AluFlags), .OpcodeCondIn(OpcodeCondIn),
        .Flags(Flags), .IrValid(IrValid), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
        .Imm8(Imm8), .Imm5(Imm5), .CarryIn(CarryIn),
`ifdef ILLEGAL_OP_TRAP_EN
        .IllegalOp(IllegalOp),
`endif
        .CondTrue(CondTrue)
    );

    logic [OBS_W-1:0] obs;
`ifdef ILLEGAL_OP_TRAP_EN
    assign obs = {OpcodeCondIn, Flags, IrValid, Rd, Rs1, Rs2, Imm8, Imm5, CarryIn, CondTrue, IllegalOp};
`else
    assign obs = {OpcodeCondIn, Flags, IrValid, Rd, Rs1, Rs2, Imm8, Imm5, CarryIn, CondTrue};
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_ir, m_shadow;
    bit          m_inburst;
    logic [3:0]  m_flags;
    bit          m_valid, m_cond, m_ill;

    function automatic bit cond_ref(int code, logic [3:0] f);
        int idx;
        bit b;
        if (code == 0) return 1'b1;
        idx = 3 - (code - 1) / 2;
        b = f[idx];
        return (code % 2 == 1) ? b : !b;
    endfunction

    function automatic bit legal_ref(logic [15:0] w);
        return (int'(w) / 2048) < 24;
    endfunction

    function automatic logic [OBS_W-1:0] exp_vec();
        int ir, i8, i5;
        logic [15:0] e8, e5;
        ir = int'(m_ir);
        i8 = ir % 256; if (i8 >= 128) i8 -= 256;
        i5 = ir % 32;  if (i5 >= 16)  i5 -= 32;
        e8 = 16'(i8);
        e5 = 16'(i5);
`ifdef ILLEGAL_OP_TRAP_EN
        return {10'(ir / 64), m_flags, m_valid, 3'((ir / 256) % 8), 3'((ir / 32) % 8),
                3'((ir / 4) % 8), e8, e5, m_flags[2], m_cond, m_ill};
`else
        return {10'(ir / 64), m_flags, m_valid, 3'((ir / 256) % 8), 3'((ir / 32) % 8),
                3'((ir / 4) % 8), e8, e5, m_flags[2], m_cond};
`endif
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit after it.
    task automatic cycle(input bit rst, input bit we, input logic [15:0] bus,
                         input bit awe, input logic [3:0] af);
        Reset = rst; IrWe = we; SysBus = bus; AluWe = awe; AluFlags = af;
        @(posedge Clock);
        if (rst) begin
            m_ir = '0; m_shadow = '0; m_inburst = 0; m_flags = '0;
            m_valid = 0; m_cond = 0; m_ill = 0;
        end else begin
            m_valid = 0;
            if (m_inburst && !we) begin
                m_valid = 1;
                m_inburst = 0;
`ifdef ILLEGAL_OP_TRAP_EN
                m_ill = !legal_ref(m_shadow);
                m_ir  = m_ill ? 16'h0000 : m_shadow;
`else
                m_ir  = m_shadow;
`endif
            end else if (we) begin
                m_shadow = bus;
                m_inburst = 1;
            end
            if (awe) m_flags = af;
            m_cond = cond_ref(int'(m_ir) / 256 % 8, m_flags);
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 16'h0, 0, 4'h0);
        cycle(1, 0, 16'h0, 0, 4'h0);
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL reset_init obs=%h exp=%h", obs, exp_vec());
        end
        cycle(0, 1, 16'hFFFF, 1, 4'hF);
        cycle(0, 0, 16'h0, 0, 4'h0);
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL reset_load_ffff obs=%h exp=%h", obs, exp_vec());
        end
        cycle(1, 1, 16'h1234, 1, 4'hF);
        n_vec++;
        if ({OpcodeCondIn, Flags, IrValid, CondTrue} !== 16'h0000) begin
            n_err++; $display("FAIL reset_clear got=%h%h%b%b want=0", OpcodeCondIn, Flags, IrValid, CondTrue);
        end
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL reset_all obs=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_burst();
        logic [15:0] words [3];
        int pulses;
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'hA5C3;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, words[i], 0, 4'h0);
            n_vec++;
            if (IrValid !== 1'b0 || OpcodeCondIn !== 10'h000) begin
                n_err++; $display("FAIL burst_hold%0d valid=%b opc=%h want 0/000", i, IrValid, OpcodeCondIn);
            end
        end
        cycle(0, 0, 16'h0, 0, 4'h0);
        n_vec++;
        if (OpcodeCondIn !== 10'h297 || Imm8 !== 16'hFFC3 || IrValid !== 1'b1) begin
            n_err++; $display("FAIL burst_commit opc=%h imm8=%h valid=%b want 297/ffc3/1", OpcodeCondIn, Imm8, IrValid);
        end
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL burst_fields obs=%h exp=%h", obs, exp_vec());
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 16'h0, 0, 4'h0);
            if (IrValid === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 0 || OpcodeCondIn !== 10'h297) begin
            n_err++; $display("FAIL burst_single_pulse extra=%0d opc=%h want 0/297", pulses, OpcodeCondIn);
        end
    endtask

    task automatic test_reset_midburst();
        int pulses;
        cycle(1, 0, 16'h0, 0, 4'h0);
        cycle(0, 1, 16'h7E55, 0, 4'h0);
        cycle(1, 1, 16'h6E66, 0, 4'h0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 16'h0, 0, 4'h0);
            if (IrValid !== 1'b0) pulses++;
        end
        n_vec++;
        if (pulses != 0 || OpcodeCondIn !== 10'h000 || Imm8 !== 16'h0000) begin
            n_err++; $display("FAIL midburst_reset pulses=%0d opc=%h imm8=%h want 0/000/0000", pulses, OpcodeCondIn, Imm8);
        end
        // FSM back in IDLE: a fresh single-cycle burst commits normally.
        cycle(0, 1, 16'h0ABC, 0, 4'h0);
        cycle(0, 0, 16'h0, 0, 4'h0);
        n_vec++;
        if (obs !== exp_vec() || IrValid !== 1'b1) begin
            n_err++; $display("FAIL midburst_recover obs=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_cond();
        logic [15:0] w [4];
        logic [3:0]  f [4];
        bit          want [4];
        w[0] = 16'h0100; f[0] = 4'b1000; want[0] = 1;
        w[1] = 16'h0100; f[1] = 4'b0000; want[1] = 0;
        w[2] = 16'h0000; f[2] = 4'b0000; want[2] = 1;
        w[3] = 16'h00FF; f[3] = 4'b1111; want[3] = 1;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 16'h0, 1, f[i]);
            cycle(0, 1, w[i], 0, 4'h0);
            cycle(0, 0, 16'h0, 0, 4'h0);
            n_vec++;
            if (CondTrue !== want[i]) begin
                n_err++; $display("FAIL cond_case%0d got=%b want=%b", i, CondTrue, want[i]);
            end
        end
    endtask

    task automatic test_same_edge();
        cycle(0, 0, 16'h0, 1, 4'h0);
        cycle(0, 1, 16'h0300, 0, 4'h0);
        cycle(0, 0, 16'h0, 1, 4'b0100);
        n_vec++;
        if (Flags !== 4'b0100 || CarryIn !== 1'b1 || OpcodeCondIn !== 10'h00C ||
            IrValid !== 1'b1 || CondTrue !== 1'b1) begin
            n_err++; $display("FAIL same_edge flags=%b cin=%b opc=%h valid=%b cond=%b want 0100/1/00c/1/1",
                              Flags, CarryIn, OpcodeCondIn, IrValid, CondTrue);
        end
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_OP_TRAP_EN
        cycle(0, 1, 16'hF8A7, 0, 4'h0);
        cycle(0, 0, 16'h0, 0, 4'h0);
        n_vec++;
        if (IllegalOp !== 1'b1 || OpcodeCondIn !== 10'h000 || Imm8 !== 16'h0000) begin
            n_err++; $display("FAIL illegal_trap ill=%b opc=%h imm8=%h want 1/000/0000", IllegalOp, OpcodeCondIn, Imm8);
        end
        cycle(0, 1, 16'h0842, 0, 4'h0);
        cycle(0, 0, 16'h0, 0, 4'h0);
        n_vec++;
        if (IllegalOp !== 1'b0 || OpcodeCondIn !== 10'h021) begin
            n_err++; $display("FAIL illegal_clear ill=%b opc=%h want 0/021", IllegalOp, OpcodeCondIn);
        end
`else
        cycle(0, 1, 16'hF8A7, 0, 4'h0);
        cycle(0, 0, 16'h0, 0, 4'h0);
        n_vec++;
        if (OpcodeCondIn !== 10'h3E2 || Imm8 !== 16'hFFA7 || Imm5 !== 16'h0007) begin
            n_err++; $display("FAIL illegal_verbatim opc=%h imm8=%h imm5=%h want 3e2/ffa7/0007", OpcodeCondIn, Imm8, Imm5);
        end
`endif
    endtask

    task automatic test_random();
        bit rst, we, awe;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            we  = ($urandom_range(0, 2) != 0);
            awe = ($urandom_range(0, 1) == 1);
            cycle(rst, we, 16'($urandom), awe, 4'($urandom));
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL random_cyc%0d obs=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_reset_midburst();
        test_cond();
        test_same_edge();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ir_decode.md
Name: ir_decode

Overview:
- Instruction-register and decode stage directly upstream of the control FSM.
- Captures the instruction word from SysBus during the fetch burst (IrWe asserted over several cycles), commits it at burst end and holds it through execute.
- Presents OpcodeCondIn[9:0] and registered Flags to control, and supplies register addresses, immediates and the branch-condition result to the datapath.
- Also owns the architectural flag register, written from ALU flags.

Parameters:
- DATA_W, 16, SysBus and instruction width
- FLAG_W, 4, flag count; order {Z,C,N,V} = [3:0]

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- SysBus  in  DATA_W  instruction word from memory pads
- IrWe  in  1  instruction write strobe from control, held for a multi-cycle burst
- AluWe  in  1  flag-register write enable
- AluFlags  in  FLAG_W  flags produced by ALU this cycle
- OpcodeCondIn  out  10  Ir[15:6] to control
- Flags  out  FLAG_W  registered flag state to control
- IrValid  out  1  one-cycle pulse when a new instruction commits
- Rd  out  3  Ir[10:8]
- Rs1  out  3  Ir[7:5]
- Rs2  out  3  Ir[4:2]
- Imm8  out  DATA_W  Ir[7:0], sign-extended
- Imm5  out  DATA_W  Ir[4:0], sign-extended
- CarryIn  out  1  registered C flag to ALU
- CondTrue  out  1  branch condition evaluated on Ir[10:8] against registered Flags

Behaviour:
- Reset (sampled at posedge): Ir=16'h0000 (NOP), Shadow=0, FlagReg=0, state=IDLE, IrValid=0, CondTrue=0. All decoded outputs follow from Ir=0.
- Reset overrides every other input on the same edge. Reset mid-burst discards Shadow; no commit occurs.
- Load FSM, 2 states:
  - IDLE: if IrWe, Shadow<=SysBus and go to LOAD.
  - LOAD, IrWe=1: Shadow<=SysBus each cycle (the last sampled word wins).
  - LOAD, IrWe=0: Ir<=Shadow, IrValid=1 for that cycle (registered pulse visible the next cycle), return to IDLE.
- Commit latency: an IrWe burst ending on edge N gives Ir updated at edge N+1. IrValid is high during the cycle after edge N+1.
- A single-cycle IrWe is legal: Shadow captured at edge N, commit at edge N+1.
- Ir is never written outside a commit. It holds unchanged through execute.
- Field decode is combinational from Ir: OpcodeCondIn=Ir[15:6], Rd/Rs1/Rs2/Imm as listed.
- Imm8 and Imm5 use two's-complement sign extension (bit 7 / bit 4 replicated).
- FlagReg:
  - AluWe=1 → FlagReg<=AluFlags at the next edge. Flags and CarryIn are driven from FlagReg.
  - AluWe and a commit on the same edge are independent; both take effect.
- CondTrue is registered, computed from the next-cycle Ir and FlagReg so it is valid the same cycle as the new Ir/Flags. Ir[10:8] codes: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 N, 110 !N, 111 V.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined:
  - Adds output IllegalOp (1 bit, registered, reset 0). It is set at commit when Ir[15:11] is not a defined opcode, and cleared at the next commit.
  - An illegal instruction is replaced by NOP (Ir<=0) at commit.
- Undefined: no port is added, and all 16-bit words commit verbatim.

Decomposition:
- opcodes package gains:
  - cond_t enum (3-bit codes above)
  - flag index constants FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0
  - function is_legal_opcode(Opcode_t)
- Load FSM state enum stays local.
- One sub-module is natural: cond_eval (combinational: cond_t + flags → CondTrue), reused later by branch prediction.

Test Plan:
- Reset with Ir already holding 16'hFFFF → next cycle Ir=0, Flags=0, IrValid=0, OpcodeCondIn=0.
- IrWe high 3 cycles with SysBus=16'h1111, 16'h2222, 16'hA5C3 then low → Ir=16'hA5C3 one edge after IrWe falls, a single IrValid pulse, OpcodeCondIn=10'h297, Imm8=16'hFFC3.
- Reset asserted during the 2nd IrWe cycle → no IrValid, Ir stays 0, FSM returns to IDLE.
- AluWe=1 with AluFlags=4'b1000, then commit Ir[10:8]=001 → CondTrue=1. Repeat with flags 0 → CondTrue=0. Code 000 → 1 regardless of flags.
- AluWe and commit on the same edge with AluFlags=4'b0100 → Flags=4'b0100, CarryIn=1, new Ir present, both in the same cycle.
- ILLEGAL_OP_TRAP_EN defined with an undefined opcode committed → IllegalOp=1 and Ir=0. With the macro undefined → the word commits unchanged.
